// File: rtl/pi_read_responder.sv
// SPI mode-0 target for Pi read commands: cmd + 17-bit address, bus-read request, data byte on MISO.
// Optional PI_READ_BURST_EN: stream consecutive addresses until spi_cs_n rises.
module pi_read_responder #(
  parameter logic [5:0] CMD_READ       = 6'h01,
  parameter logic [7:0] TURN_BYTE      = 8'hA5,
  parameter logic [7:0] NOT_READY_BYTE = 8'hFF
) (
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_rx,
  output logic        spi_tx,
  output logic [16:0] pi_addr,
  output logic        pi_rw_b,
  output logic        pi_pending_out,
  input  logic        pi_done_in,
  input  logic [7:0]  pi_data_in,
  output logic        rd_err
);

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, TURN, DATA, IGNORE} state_t;

  state_t      state, state_n;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_sr, tx_sr, tx_n, addr_hi, hi_n;
  logic        a16, a16_n, pend_n, err_n, rearm, rearm_n, sample;
  logic [16:0] addr_n;
  logic        frame_rst;

  assign frame_rst = reset | spi_cs_n;
  assign spi_tx    = tx_sr[7];
  assign pi_rw_b   = 1'b1;

  always_ff @(posedge spi_sclk or posedge frame_rst) begin
    if (frame_rst) rx_sr <= '0;
    else           rx_sr <= {rx_sr[6:0], spi_rx};
  end

  always_comb begin
    state_n = state;
    tx_n    = {tx_sr[6:0], 1'b0};
    pend_n  = pi_pending_out;
    addr_n  = pi_addr;
    err_n   = rd_err;
    a16_n   = a16;
    hi_n    = addr_hi;
    rearm_n = 1'b0;
    sample  = 1'b0;
`ifdef PI_READ_BURST_EN
    if (rearm) pend_n = 1'b1;
`endif
    if (bit_cnt == 3'd7) begin
      case (state)
        IDLE: begin
          if (rx_sr[7] && rx_sr[5:0] == CMD_READ) begin
            state_n = ADDR_HI;
            a16_n   = rx_sr[6];
          end else begin
            state_n = IGNORE;
          end
        end
        ADDR_HI: begin
          hi_n    = rx_sr;
          state_n = ADDR_LO;
        end
        ADDR_LO: begin
          addr_n  = {a16, addr_hi, rx_sr};
          pend_n  = 1'b1;
          tx_n    = TURN_BYTE;
          state_n = TURN;
        end
        TURN: begin
          sample  = 1'b1;
          state_n = DATA;
        end
        DATA: begin
`ifdef PI_READ_BURST_EN
          sample  = 1'b1;
`else
          tx_n    = '0;
          state_n = IGNORE;
`endif
        end
        default: state_n = IGNORE;
      endcase
    end
    if (sample) begin
      pend_n = 1'b0;
      if (pi_done_in) begin
        tx_n = pi_data_in;
      end else begin
        tx_n  = NOT_READY_BYTE;
        err_n = 1'b1;
      end
`ifdef PI_READ_BURST_EN
      // Next address goes out after one idle sclk so the arbiter sees pending low.
      addr_n  = pi_addr + 17'd1;
      rearm_n = 1'b1;
`endif
    end
  end

  always_ff @(negedge spi_sclk or posedge frame_rst) begin
    if (frame_rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      tx_sr          <= '0;
      pi_pending_out <= 1'b0;
      a16            <= 1'b0;
      addr_hi        <= '0;
      rearm          <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt + 3'd1;
      tx_sr          <= tx_n;
      pi_pending_out <= pend_n;
      a16            <= a16_n;
      addr_hi        <= hi_n;
      rearm          <= rearm_n;
    end
  end

  // Address and error flag survive spi_cs_n; only the global reset clears them.
  always_ff @(negedge spi_sclk or posedge reset) begin
    if (reset) begin
      pi_addr <= '0;
      rd_err  <= 1'b0;
    end else if (!spi_cs_n) begin
      pi_addr <= addr_n;
      rd_err  <= err_n;
    end
  end

endmodule

// File: tb/tb_pi_read_responder.sv
// Directed bench for pi_read_responder: bit-banged SPI frames, scripted arbiter, MISO scoreboard.
module tb_pi_read_responder;

  logic        reset, spi_sclk, spi_cs_n, spi_rx, spi_tx;
  logic [16:0] pi_addr;
  logic        pi_rw_b, pi_pending_out, pi_done_in, rd_err;
  logic [7:0]  pi_data_in;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  arb_q[$];
  logic [16:0] addr_seen[$];
  bit          arb_en, pend_seen;
  int          arb_delay, arb_cnt;
  logic [7:0]  got;

  pi_read_responder dut (
    .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_rx(spi_rx), .spi_tx(spi_tx),
    .pi_addr(pi_addr), .pi_rw_b(pi_rw_b), .pi_pending_out(pi_pending_out),
    .pi_done_in(pi_done_in), .pi_data_in(pi_data_in), .rd_err(rd_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arbiter: answers a pending request arb_delay sclks later, drops done once pending falls.
  task automatic arb_step();
    if (!pi_pending_out) begin
      pi_done_in = 1'b0;
      arb_cnt    = 0;
    end else begin
      pend_seen = 1'b1;
      if (arb_en && !pi_done_in) begin
        arb_cnt++;
        if (arb_cnt >= arb_delay && arb_q.size() > 0) begin
          pi_data_in = arb_q.pop_front();
          addr_seen.push_back(pi_addr);
          pi_done_in = 1'b1;
        end
      end
    end
  endtask

  task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    miso = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_rx = mosi[i];
      #3 miso[i] = spi_tx;
      #2 spi_sclk = 1'b1;
      #1 arb_step();
      #3 spi_sclk = 1'b0;
      #1;
    end
  endtask

  task automatic sb_byte(input logic [7:0] mosi, input logic [7:0] exp, input string tag);
    logic [7:0] rx;
    exp_q.push_back(exp);
    xfer(mosi, 8, rx);
    chk(tag, rx, exp_q.pop_front());
  endtask

  task automatic chk_req(input string tag, input logic [16:0] exp);
    logic [16:0] a;
    a = (addr_seen.size() > 0) ? addr_seen.pop_front() : 17'h1xxxx;
    chk(tag, a, exp);
  endtask

  initial begin
    reset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_rx = 1'b0;
    pi_done_in = 1'b0; pi_data_in = '0; arb_en = 1'b0; arb_delay = 2; arb_cnt = 0;
    pend_seen = 1'b0;
    #10;
    chk("rst_pending", pi_pending_out, 0);
    chk("rst_addr", pi_addr, 0);
    chk("rst_tx", spi_tx, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_rw_b", pi_rw_b, 1);
    reset = 1'b0;
    #10;

`ifdef PI_READ_BURST_EN
    arb_q = '{8'h11, 8'h22, 8'h33};
    arb_en = 1'b1; arb_delay = 2;
    spi_cs_n = 1'b0; #5;
    sb_byte(8'hC1, 8'h00, "bu_b0");
    sb_byte(8'hFF, 8'h00, "bu_b1");
    sb_byte(8'hFE, 8'h00, "bu_b2");
    chk("bu_addr", pi_addr, 17'h1FFFE);
    sb_byte(8'h00, 8'hA5, "bu_turn");
    sb_byte(8'h00, 8'h11, "bu_d0");
    sb_byte(8'h00, 8'h22, "bu_d1");
    sb_byte(8'h00, 8'h33, "bu_d2");
    chk_req("bu_req0", 17'h1FFFE);
    chk_req("bu_req1", 17'h1FFFF);
    chk_req("bu_req2", 17'h00000);
    chk("bu_err", rd_err, 0);
    spi_cs_n = 1'b1; #10;
`else
    // Normal read of 0x01234, data ready 2 sclk after the request
    arb_q.push_back(8'h5A);
    arb_en = 1'b1; arb_delay = 2;
    spi_cs_n = 1'b0; #5;
    sb_byte(8'h81, 8'h00, "t1_b0");
    sb_byte(8'h12, 8'h00, "t1_b1");
    sb_byte(8'h34, 8'h00, "t1_b2");
    chk("t1_pend_rise", pi_pending_out, 1);
    chk("t1_addr", pi_addr, 17'h01234);
    sb_byte(8'h00, 8'hA5, "t1_turn");
    chk("t1_pend_fall", pi_pending_out, 0);
    chk_req("t1_req", 17'h01234);
    sb_byte(8'h00, 8'h5A, "t1_data");
    pend_seen = 1'b0;
    sb_byte(8'h00, 8'h00, "t1_extra");
    chk("t1_no_rereq", pend_seen, 0);
    chk("t1_err", rd_err, 0);
    spi_cs_n = 1'b1; #10;

    // Arbiter never answers
    arb_en = 1'b0;
    spi_cs_n = 1'b0; #5;
    sb_byte(8'h81, 8'h00, "t2_b0");
    sb_byte(8'h12, 8'h00, "t2_b1");
    sb_byte(8'h34, 8'h00, "t2_b2");
    sb_byte(8'h00, 8'hA5, "t2_turn");
    chk("t2_pend_fall", pi_pending_out, 0);
    sb_byte(8'h00, 8'hFF, "t2_notready");
    chk("t2_err", rd_err, 1);
    spi_cs_n = 1'b1; #10;

    // Write command (rw_b=0) is ignored
    pend_seen = 1'b0;
    spi_cs_n = 1'b0; #5;
    sb_byte(8'h01, 8'h00, "t3_b0");
    sb_byte(8'h12, 8'h00, "t3_b1");
    sb_byte(8'h34, 8'h00, "t3_b2");
    sb_byte(8'h00, 8'h00, "t3_b3");
    sb_byte(8'h00, 8'h00, "t3_b4");
    chk("t3_no_pend", pend_seen, 0);
    chk("t3_err_sticky", rd_err, 1);
    spi_cs_n = 1'b1; #10;

    // Reset pulse in the middle of B2
    spi_cs_n = 1'b0; #5;
    sb_byte(8'h81, 8'h00, "t4_b0");
    sb_byte(8'h12, 8'h00, "t4_b1");
    xfer(8'h34, 4, got);
    #2 reset = 1'b1;
    #1;
    chk("t4_addr", pi_addr, 0);
    chk("t4_err", rd_err, 0);
    chk("t4_pending", pi_pending_out, 0);
    chk("t4_tx", spi_tx, 0);
    chk("t4_rw_b", pi_rw_b, 1);
    #2 reset = 1'b0;
    spi_cs_n = 1'b1; #10;

    // cs_n rises mid-B3 while the request is pending
    spi_cs_n = 1'b0; #5;
    sb_byte(8'h81, 8'h00, "t5_b0");
    sb_byte(8'h12, 8'h00, "t5_b1");
    sb_byte(8'h34, 8'h00, "t5_b2");
    xfer(8'h00, 4, got);
    chk("t5_pend_before", pi_pending_out, 1);
    #2 spi_cs_n = 1'b1;
    #1;
    chk("t5_pend_abort", pi_pending_out, 0);
    chk("t5_tx_abort", spi_tx, 0);
    #10;

    // Following frame reads 0x10000
    arb_q.push_back(8'h3C);
    arb_en = 1'b1; arb_delay = 1;
    spi_cs_n = 1'b0; #5;
    sb_byte(8'hC1, 8'h00, "t6_b0");
    sb_byte(8'h00, 8'h00, "t6_b1");
    sb_byte(8'h00, 8'h00, "t6_b2");
    chk("t6_addr", pi_addr, 17'h10000);
    sb_byte(8'h00, 8'hA5, "t6_turn");
    sb_byte(8'h00, 8'h3C, "t6_data");
    chk_req("t6_req", 17'h10000);
    chk("t6_err", rd_err, 0);
    spi_cs_n = 1'b1; #10;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
